mem_sram_controller: RTL and testbench
======================================

# mem_sram_controller

Responder side of the MEM-stage data-memory access. Accepts a one-word load or store request from the EXE/MEM boundary (ALU result as address, store value, read/write enables) and serves it from an external 16-bit asynchronous SRAM as two half-word accesses. While the access is in flight it holds `ready` low so the pipeline registers freeze. On completion it presents the 32-bit load value that feeds the MEM stage register's memory-read-value input.

## Interface
- `BIT_NUMBER`, 32: data/address word width.
- `WAIT_CYCLES`, 2: extra settle cycles after the second half-word access, range 0–7.
- `clk` input 1: single clock; all state changes on rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `wr_en` input 1: store request, level, held by requester until `ready`.
- `rd_en` input 1: load request, level, held by requester until `ready`.
- `address` input BIT_NUMBER: byte address (ALU result), word-aligned.
- `write_data` input BIT_NUMBER: store value.
- `read_data` output BIT_NUMBER: load value, registered.
- `ready` output 1: high = no access pending; low = freeze pipeline.
- `SRAM_DQ` inout 16: SRAM data bus, driven only during write half-accesses, else high-Z.
- `SRAM_ADDR` output 18: SRAM half-word address, registered.
- `SRAM_WE_N` output 1: SRAM write enable, active-low, registered.
- `SRAM_UB_N`, `SRAM_LB_N`, `SRAM_CE_N`, `SRAM_OE_N` output 1 each: constant 0.

## Operation
- Address map: `idx = (address − 1024) >> 2`, truncated to 17 bits (modulo wrap, no range error). Low half at `{idx,0}`, high half at `{idx,1}`.
- FSM states: IDLE, LOW, HIGH, WAIT, DONE.
- IDLE: if `wr_en` or `rd_en`, latch op (write has priority when both high; treated as write only), address, and `write_data`; go to LOW. Otherwise stay.
- LOW: `SRAM_ADDR={idx,0}`.
  - Write: `SRAM_WE_N=0`, DQ drives `write_data[15:0]`.
  - Read: `SRAM_WE_N=1`, DQ is Z, `read_data[15:0]` is captured at the end of the cycle.
  - Go to HIGH.
- HIGH: same as LOW with `{idx,1}` and bits [31:16]. Go to WAIT if `WAIT_CYCLES>0`, else DONE.
- WAIT: `SRAM_WE_N=1`, DQ is Z. Counter counts `WAIT_CYCLES` cycles, then goes to DONE.
- DONE: `SRAM_WE_N=1`. Go to IDLE unconditionally. Request inputs are ignored in DONE; they belong to the finishing request.
- `ready = (IDLE && !rd_en && !wr_en) || DONE` (combinational, so the freeze applies in the request cycle).
- `read_data` is unchanged by writes and holds its last load value until the next load or reset.
- Reset (any state, including mid-access):
  - State goes to IDLE, wait counter to 0.
  - `read_data`=0, `SRAM_ADDR`=0, `SRAM_WE_N`=1, DQ Z.
  - An interrupted write may leave one half-word written; this is acceptable.

## Timing
- Request first seen in IDLE at cycle T:
  - LOW at T+1, HIGH at T+2, WAIT at T+3..T+2+W, DONE at T+3+W.
  - `ready` is low for cycles T..T+2+W (3+W cycles) and high in cycle T+3+W.
  - Default W=2: ready low 5 cycles, high at T+5.
- `read_data` is final from DONE onward and is valid when `ready` first rises. The pipeline advances on the edge closing DONE.
- Back-to-back: the next request is visible in the IDLE cycle T+4+W. No request is dropped or duplicated.
- No request in IDLE: `ready` stays 1, SRAM stays idle (`WE_N=1`, DQ Z).

## Test plan
- Store 0xDEADBEEF at address 1024 -> `SRAM_ADDR`/data pairs are 0/0xBEEF (T+1) then 1/0xDEAD (T+2), `WE_N` low only in those cycles; `ready` is 0 for T..T+4 and 1 at T+5.
- Load from 1024 after that store -> `read_data`=0xDEADBEEF at T+5. Load from 1028 after storing 0x12345678 there -> `SRAM_ADDR` 2 then 3, `read_data`=0x12345678.
- `rd_en` and `wr_en` both high with `write_data`=0xA5A5_5A5A -> write performed, `read_data` unchanged.
- Back-to-back store then load at 1032 -> second access starts at T+6. Exactly two write half-cycles and two read half-cycles occur. Data round-trips.
- `rst` pulsed at T+2 of a write -> next cycle IDLE, `WE_N`=1, DQ Z, `read_data`=0, `ready`=1 with enables low.
- `WAIT_CYCLES`=0 -> DONE at T+3, `ready` low exactly 3 cycles. Address 1020 -> idx wraps to 0x1FFFF, `SRAM_ADDR` 0x3FFFE/0x3FFFF.

Source files
------------

// File: rtl/mem_sram_controller.sv
// MEM-stage data-memory responder: serves one 32-bit load/store as two
// half-word accesses on an external 16-bit asynchronous SRAM.
module mem_sram_controller #(
   parameter int BIT_NUMBER  = 32,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [BIT_NUMBER-1:0] address,
   input  logic [BIT_NUMBER-1:0] write_data,
   output logic [BIT_NUMBER-1:0] read_data,
   output logic                  ready,
   inout  wire  [15:0]           SRAM_DQ,
   output logic [17:0]           SRAM_ADDR,
   output logic                  SRAM_WE_N,
   output logic                  SRAM_UB_N,
   output logic                  SRAM_LB_N,
   output logic                  SRAM_CE_N,
   output logic                  SRAM_OE_N
);

   typedef enum logic [2:0] {IDLE, LOW, HIGH, WAIT, DONE} state_t;

   localparam logic [2:0] WAIT_LAST = 3'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

   state_t                  state_reg, state_next;
   logic [2:0]              wait_cnt_reg, wait_cnt_next;
   logic                    is_write_reg;
   logic [16:0]             idx_reg;
   logic [15:0]             wdata_hi_reg;
   logic [BIT_NUMBER-1:0]   read_data_reg;
   logic [17:0]             sram_addr_reg, sram_addr_next;
   logic                    we_n_reg, we_n_next;
   logic                    dq_oe_reg, dq_oe_next;
   logic [15:0]             dq_out_reg, dq_out_next;
   logic                    req;
   logic [16:0]             idx_in;

   assign req    = wr_en | rd_en;
   // Data segment starts at byte 1024; wrap modulo 2^17 words.
   assign idx_in = 17'((address - BIT_NUMBER'(1024)) >> 2);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         wait_cnt_reg  <= '0;
         is_write_reg  <= 1'b0;
         idx_reg       <= '0;
         wdata_hi_reg  <= '0;
         read_data_reg <= '0;
         sram_addr_reg <= '0;
         we_n_reg      <= 1'b1;
         dq_oe_reg     <= 1'b0;
         dq_out_reg    <= '0;
      end else begin
         state_reg     <= state_next;
         wait_cnt_reg  <= wait_cnt_next;
         sram_addr_reg <= sram_addr_next;
         we_n_reg      <= we_n_next;
         dq_oe_reg     <= dq_oe_next;
         dq_out_reg    <= dq_out_next;
         if (state_reg == IDLE && req) begin
            is_write_reg <= wr_en;
            idx_reg      <= idx_in;
            wdata_hi_reg <= write_data[31:16];
         end
         if (state_reg == LOW && !is_write_reg)
            read_data_reg[15:0] <= SRAM_DQ;
         if (state_reg == HIGH && !is_write_reg)
            read_data_reg[31:16] <= SRAM_DQ;
      end
   end

   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      case (state_reg)
         IDLE: if (req) state_next = LOW;
         LOW:  state_next = HIGH;
         HIGH: begin
            if (WAIT_CYCLES > 0) begin
               state_next    = WAIT;
               wait_cnt_next = '0;
            end else begin
               state_next = DONE;
            end
         end
         WAIT: begin
            if (wait_cnt_reg == WAIT_LAST) state_next = DONE;
            else                           wait_cnt_next = wait_cnt_reg + 3'd1;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // SRAM pins are registered, so they are set up one cycle ahead of the half-access.
   always_comb begin
      ready          = (state_reg == IDLE && !req) || (state_reg == DONE);
      sram_addr_next = sram_addr_reg;
      we_n_next      = 1'b1;
      dq_oe_next     = 1'b0;
      dq_out_next    = dq_out_reg;
      case (state_reg)
         IDLE: begin
            if (req) begin
               sram_addr_next = {idx_in, 1'b0};
               we_n_next      = !wr_en;
               dq_oe_next     = wr_en;
               dq_out_next    = write_data[15:0];
            end
         end
         LOW: begin
            sram_addr_next = {idx_reg, 1'b1};
            we_n_next      = !is_write_reg;
            dq_oe_next     = is_write_reg;
            dq_out_next    = wdata_hi_reg;
         end
         default: ;
      endcase
   end

   assign SRAM_DQ   = dq_oe_reg ? dq_out_reg : 16'hzzzz;
   assign SRAM_ADDR = sram_addr_reg;
   assign SRAM_WE_N = we_n_reg;
   assign read_data = read_data_reg;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_mem_sram_controller.sv
// Bench for mem_sram_controller: unit 0 uses WAIT_CYCLES=0, unit 1 the default 2,
// each with its own behavioural asynchronous SRAM.
module tb_mem_sram_controller;

   logic        clk;
   logic        rst;
   logic        wr_en_v     [2];
   logic        rd_en_v     [2];
   logic [31:0] address_v   [2];
   logic [31:0] write_data_v[2];
   logic [31:0] rdata_v     [2];
   logic        ready_v     [2];
   logic [17:0] saddr_v     [2];
   logic        wen_v       [2];
   logic [3:0]  pins_v      [2];

   int errors = 0;
   int checks = 0;

   logic [34:0] exp_wr_q[$];     // {unit, sram address, half-word}
   logic [31:0] exp_rd_q[$];
   logic [31:0] shadow [logic [32:0]];
   logic [31:0] last_load [2];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   initial clk = 1'b0;
   always #5 clk = ~clk;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_unit
         wire  [15:0] dq;
         logic [31:0] rd;
         logic        rdy;
         logic [17:0] sa;
         logic        wen, ub, lb, ce, oe;
         logic [15:0] mem [0:262143];
         logic [34:0] e;

         mem_sram_controller #(.BIT_NUMBER(32), .WAIT_CYCLES((gi == 0) ? 0 : 2)) dut (
            .clk(clk), .rst(rst),
            .wr_en(wr_en_v[gi]), .rd_en(rd_en_v[gi]),
            .address(address_v[gi]), .write_data(write_data_v[gi]),
            .read_data(rd), .ready(rdy),
            .SRAM_DQ(dq), .SRAM_ADDR(sa), .SRAM_WE_N(wen),
            .SRAM_UB_N(ub), .SRAM_LB_N(lb), .SRAM_CE_N(ce), .SRAM_OE_N(oe)
         );

         assign dq = wen ? mem[sa] : 16'hzzzz;
         always @(posedge clk) if (!wen) mem[sa] <= dq;

         assign rdata_v[gi] = rd;
         assign ready_v[gi] = rdy;
         assign saddr_v[gi] = sa;
         assign wen_v[gi]   = wen;
         assign pins_v[gi]  = {ub, lb, ce, oe};

         // Every write half-cycle seen on the bus must match the next expected one.
         always @(negedge clk) begin
            if (!wen) begin
               if (exp_wr_q.size() == 0) begin
                  check("wr_unexpected", 64'(sa), 64'h3ffff_ffff);
               end else begin
                  e = exp_wr_q.pop_front();
                  check("wr_half", 64'({1'(gi), sa, dq}), 64'(e));
               end
            end
         end
      end
   endgenerate

   task automatic access(input int u, input bit wr, input bit rd, input logic [31:0] a,
                         input logic [31:0] d, input string tag);
      logic [16:0] idx;
      int          lowc;
      int          w;
      w   = (u == 0) ? 0 : 2;
      idx = 17'((a - 32'd1024) >> 2);
      if (wr) begin
         shadow[{1'(u), a}] = d;
         exp_wr_q.push_back({1'(u), idx, 1'b0, d[15:0]});
         exp_wr_q.push_back({1'(u), idx, 1'b1, d[31:16]});
      end else if (rd) begin
         last_load[u] = shadow[{1'(u), a}];
      end
      exp_rd_q.push_back(last_load[u]);

      @(posedge clk); #1;
      wr_en_v[u] = wr; rd_en_v[u] = rd; address_v[u] = a; write_data_v[u] = d;
      @(negedge clk);
      check({tag, "_ready_req"}, 64'(ready_v[u]), 64'd0);
      lowc = 1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) begin
            check({tag, "_addr_lo"}, 64'(saddr_v[u]), 64'({idx, 1'b0}));
            check({tag, "_wen_lo"}, 64'(wen_v[u]), 64'(!wr));
         end else if (k == 2) begin
            check({tag, "_addr_hi"}, 64'(saddr_v[u]), 64'({idx, 1'b1}));
            check({tag, "_wen_hi"}, 64'(wen_v[u]), 64'(!wr));
         end else begin
            check({tag, "_wen_idle"}, 64'(wen_v[u]), 64'd1);
         end
         if (ready_v[u]) break;
         lowc++;
      end
      check({tag, "_ready_low_cycles"}, 64'(lowc), 64'(3 + w));
      check({tag, "_read_data"}, 64'(rdata_v[u]), 64'(exp_rd_q.pop_front()));
   endtask

   task automatic idle(input int n);
      @(posedge clk); #1;
      for (int u = 0; u < 2; u++) begin
         wr_en_v[u] = 1'b0; rd_en_v[u] = 1'b0;
      end
      repeat (n) begin
         @(negedge clk);
         check("idle_ready", 64'({ready_v[0], ready_v[1]}), 64'b11);
         check("idle_wen", 64'({wen_v[0], wen_v[1]}), 64'b11);
      end
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] d;
      rst = 1'b1;
      for (int u = 0; u < 2; u++) begin
         wr_en_v[u] = 1'b0; rd_en_v[u] = 1'b0;
         address_v[u] = '0; write_data_v[u] = '0; last_load[u] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 64'({ready_v[0], ready_v[1]}), 64'b11);
      check("rst_read_data", 64'(rdata_v[1]), 64'd0);
      check("rst_sram_addr", 64'(saddr_v[1]), 64'd0);
      check("rst_wen", 64'({wen_v[0], wen_v[1]}), 64'b11);
      check("const_pins", 64'({pins_v[0], pins_v[1]}), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      idle(3);

      access(1, 1, 0, 32'd1024, 32'hDEADBEEF, "st1024");
      idle(2);
      access(1, 0, 1, 32'd1024, 32'h0, "ld1024");
      access(1, 1, 0, 32'd1028, 32'h12345678, "st1028");
      access(1, 0, 1, 32'd1028, 32'h0, "ld1028");
      idle(1);
      access(1, 1, 1, 32'd1024, 32'hA5A55A5A, "both");
      access(1, 0, 1, 32'd1024, 32'h0, "ld_both");
      idle(1);
      access(1, 1, 0, 32'd1032, 32'hCAFEF00D, "b2b_st");
      access(1, 0, 1, 32'd1032, 32'h0, "b2b_ld");
      idle(2);

      for (int i = 0; i < 4; i++) begin
         a = 32'd1024 + 32'($urandom_range(0, 4000)) * 4;
         d = $urandom;
         access(1, 1, 0, a, d, "rnd_st");
         access(1, 0, 1, a, 32'h0, "rnd_ld");
      end
      idle(1);

      // Reset lands on the edge closing the HIGH half of a store.
      a = 32'd1036;
      d = 32'h13579BDF;
      exp_wr_q.push_back({1'b1, 17'((a - 32'd1024) >> 2), 1'b0, d[15:0]});
      exp_wr_q.push_back({1'b1, 17'((a - 32'd1024) >> 2), 1'b1, d[31:16]});
      @(posedge clk); #1;
      wr_en_v[1] = 1'b1; address_v[1] = a; write_data_v[1] = d;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1; wr_en_v[1] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      last_load[0] = '0; last_load[1] = '0;
      @(negedge clk);
      check("rstmid_ready", 64'(ready_v[1]), 64'd1);
      check("rstmid_wen", 64'(wen_v[1]), 64'd1);
      check("rstmid_read_data", 64'(rdata_v[1]), 64'd0);
      idle(2);

      access(0, 1, 0, 32'd1020, 32'h0BADF00D, "w0_st1020");
      access(0, 0, 1, 32'd1020, 32'h0, "w0_ld1020");
      access(0, 1, 0, 32'd2048, 32'h600DCAFE, "w0_st2048");
      access(0, 0, 1, 32'd2048, 32'h0, "w0_ld2048");
      idle(2);

      check("wr_queue_drained", 64'(exp_wr_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
